// File: rtl/hack_fetch_pkg.sv
// Shared Hack platform widths and the fetch payload carried from ROM32K to the CPU.
package hack_pkg;
  localparam int unsigned ADDR_W     = 15;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned OCC_W      = 2;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/hack_fetch_if.sv
// Instruction stream from the fetch stage to the CPU, valid/ready handshake.
interface hack_fetch_if;
  import hack_pkg::*;

  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;

  modport master (output instr, output instr_pc, output instr_valid, input instr_ready);
  modport slave  (input instr, input instr_pc, input instr_valid, output instr_ready);
endinterface

// File: rtl/hack_fetch_skid_fifo.sv
// Two-entry shift FIFO; entry 0 is always the head so the outputs come straight from flops.
module fetch_skid_fifo
  import hack_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  fetch_entry_t     i_data,
  output fetch_entry_t     o_head,
  output logic             o_valid,
  output logic [OCC_W-1:0] o_occ
);
  fetch_entry_t     r_ent0, r_ent1;
  logic [OCC_W-1:0] r_occ;
  logic             r_valid;

  fetch_entry_t     w_ent0_nxt, w_ent1_nxt;
  logic [OCC_W-1:0] w_occ_pop, w_occ_nxt;
  logic             w_pop;

  // Pop shifts the tail forward; push lands in the first free slot after the pop.
  always_comb begin
    w_ent0_nxt = r_ent0;
    w_ent1_nxt = r_ent1;
    w_pop      = i_pop & r_valid;
    w_occ_pop  = r_occ - OCC_W'(w_pop);
    if (w_pop && (r_occ == OCC_W'(FIFO_DEPTH))) w_ent0_nxt = r_ent1;
    if (i_push) begin
      if (w_occ_pop == '0) w_ent0_nxt = i_data;
      else                 w_ent1_nxt = i_data;
    end
    w_occ_nxt = w_occ_pop + OCC_W'(i_push);
    if (i_flush) w_occ_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ent0  <= '0;
      r_ent1  <= '0;
      r_occ   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_ent0  <= w_ent0_nxt;
      r_ent1  <= w_ent1_nxt;
      r_occ   <= w_occ_nxt;
      r_valid <= (w_occ_nxt != '0);
    end
  end

  assign o_head  = r_ent0;
  assign o_valid = r_valid;
  assign o_occ   = r_occ;
endmodule

// File: rtl/hack_fetch.sv
// Hack instruction fetch: owns the PC, drives ROM32K, buffers one-cycle-latency reads for the CPU.
module hack_fetch
  import hack_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  hack_fetch_if.master      fetch_bus
);
  logic [ADDR_W-1:0] r_fpc;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_req_q;

  fetch_entry_t      w_head, w_push_data;
  logic              w_valid, w_pop, w_push, w_issue;
  logic [OCC_W-1:0]  w_occ;
  logic [OCC_W:0]    w_committed;

  // Only issue when the buffer can still absorb this read next cycle, so rom_data is never dropped.
  always_comb begin
    w_pop       = w_valid & fetch_bus.instr_ready;
    w_committed = {1'b0, w_occ} + (OCC_W+1)'(r_req_q) - (OCC_W+1)'(w_pop);
    w_issue     = ~reset & ~jump & (w_committed < (OCC_W+1)'(FIFO_DEPTH));
    w_push      = r_req_q & ~jump;
    w_push_data = '{instr: rom_data, pc: r_req_pc};
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_fpc    <= RESET_PC;
      r_req_q  <= 1'b0;
      r_req_pc <= '0;
    end else if (jump) begin
      r_fpc   <= jump_target;
      r_req_q <= 1'b0;
    end else if (w_issue) begin
      r_fpc    <= r_fpc + ADDR_W'(1);
      r_req_q  <= 1'b1;
      r_req_pc <= r_fpc;
    end else begin
      r_req_q <= 1'b0;
    end
  end

  fetch_skid_fifo u_fifo (
    .clk     (CLK),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (jump),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_valid (w_valid),
    .o_occ   (w_occ)
  );

  assign rom_address           = r_fpc;
  assign fetch_bus.instr       = w_head.instr;
  assign fetch_bus.instr_pc    = w_head.pc;
  assign fetch_bus.instr_valid = w_valid;
endmodule

// File: tb/tb_hack_fetch.sv
// Directed and random checks of hack_fetch against a ROM model and an expected-stream scoreboard.
module tb_hack_fetch;
  import hack_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              jump;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] rom_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int xfers = 0;
  fetch_entry_t      exp_q[$];
  logic [ADDR_W-1:0] seq;

  always #5 clk = ~clk;

  hack_fetch_if bus ();

  hack_fetch #(.RESET_PC('0)) dut (
    .CLK         (clk),
    .reset       (reset),
    .rom_address (rom_address),
    .rom_data    (rom_data),
    .jump        (jump),
    .jump_target (jump_target),
    .fetch_bus   (bus)
  );

  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return 16'hA000 | DATA_W'(a);
  endfunction

  // ROM32K: synchronous read, one cycle of latency.
  always_ff @(posedge clk) rom_data <= rom_word(rom_address);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refill();
    fetch_entry_t e;
    while (exp_q.size() < 4) begin
      e.pc    = seq;
      e.instr = rom_word(seq);
      exp_q.push_back(e);
      seq = seq + ADDR_W'(1);
    end
  endtask

  task automatic sb_restart(input logic [ADDR_W-1:0] start);
    exp_q.delete();
    seq = start;
    refill();
  endtask

  // Score this cycle's transfer, apply redirects to the expected stream, advance one clock.
  task automatic tick();
    fetch_entry_t e;
    if (!reset && bus.instr_valid && bus.instr_ready) begin
      xfers++;
      e = exp_q.pop_front();
      chk("xfer_pc", 32'(bus.instr_pc), 32'(e.pc));
      chk("xfer_instr", 32'(bus.instr), 32'(e.instr));
      refill();
    end
    if (reset)     sb_restart('0);
    else if (jump) sb_restart(jump_target);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"},  32'(rom_address), 0);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 0);
    chk({tag, "_instr"}, 32'(bus.instr), 0);
    chk({tag, "_pc"},    32'(bus.instr_pc), 0);
  endtask

  // First cycles after reset release: valid rises in cycle 2 with pc 0.
  task automatic start_seq();
    reset = 1'b0;
    bus.instr_ready = 1'b1;
    cyc = 0;
    chk("c0_addr", 32'(rom_address), 0);
    chk("c0_valid", 32'(bus.instr_valid), 0);
    tick();
    chk("c1_valid", 32'(bus.instr_valid), 0);
    tick();
    chk("c2_valid", 32'(bus.instr_valid), 1);
    chk("c2_pc", 32'(bus.instr_pc), 0);
    chk("c2_instr", 32'(bus.instr), 32'h0000_A000);
    tick();
  endtask

  initial begin
    logic [ADDR_W-1:0] wrap_pcs[4];
    wrap_pcs[0] = 15'h7FFE; wrap_pcs[1] = 15'h7FFF; wrap_pcs[2] = 15'h0000; wrap_pcs[3] = 15'h0001;

    reset = 1'b1; jump = 1'b0; jump_target = '0; bus.instr_ready = 1'b1;
    sb_restart('0);
    repeat (3) tick();
    chk_reset_vals("rst");

    // Streaming then backpressure in cycles 4..9.
    start_seq();
    chk("c3_pc", 32'(bus.instr_pc), 1);
    tick();
    bus.instr_ready = 1'b0;
    while (cyc <= 9) begin
      chk("bp_valid", 32'(bus.instr_valid), 1);
      chk("bp_pc", 32'(bus.instr_pc), 2);
      if (cyc >= 5) chk("bp_addr", 32'(rom_address), 4);
      tick();
    end
    bus.instr_ready = 1'b1;
    chk("rel_pc", 32'(bus.instr_pc), 2);
    while (cyc <= 14) begin
      chk("drain_valid", 32'(bus.instr_valid), 1);
      tick();
    end

    // Jump to 0x0100 in cycle 6.
    reset = 1'b1; tick();
    start_seq();
    while (cyc < 6) tick();
    jump = 1'b1; jump_target = 15'h0100;
    tick();
    jump = 1'b0;
    chk("j1_addr", 32'(rom_address), 32'h100);
    chk("j1_valid", 32'(bus.instr_valid), 0);
    tick();
    chk("j2_valid", 32'(bus.instr_valid), 0);
    tick();
    chk("j3_valid", 32'(bus.instr_valid), 1);
    chk("j3_pc", 32'(bus.instr_pc), 32'h100);
    chk("j3_instr", 32'(bus.instr), 32'h0000_A100);
    repeat (4) tick();

    // Jump near the top of the address space.
    jump = 1'b1; jump_target = 15'h7FFE;
    tick();
    jump = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      chk("wrap_valid", 32'(bus.instr_valid), 1);
      chk("wrap_pc", 32'(bus.instr_pc), 32'(wrap_pcs[i]));
      tick();
    end

    // Reset and jump together while the buffer is full.
    bus.instr_ready = 1'b0;
    repeat (4) tick();
    chk("full_valid", 32'(bus.instr_valid), 1);
    reset = 1'b1; jump = 1'b1; jump_target = 15'h1234;
    tick();
    jump = 1'b0;
    chk_reset_vals("rstjmp");
    tick();
    start_seq();
    chk("rs_c3_pc", 32'(bus.instr_pc), 1);
    tick();

    // Random backpressure and redirects.
    xfers = 0;
    for (int i = 0; i < 10000; i++) begin
      bus.instr_ready = 1'($urandom_range(1, 0));
      jump = ($urandom_range(99, 0) < 3);
      jump_target = ADDR_W'($urandom());
      tick();
    end
    jump = 1'b0;
    chk("rand_progress", 32'(xfers > 2000), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
